// File: rtl/instruction_fetch.sv
// Instruction fetch front end: req/ack byte fetcher feeding a small prefetch queue
// that presents one opcode byte per cycle to the decode stage.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [7:0]            NOP          = 8'h00
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_suppress,
  input  logic                  i_pc_load,
  input  logic [ADDR_WIDTH-1:0] i_pc_load_value,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [7:0]            i_mem_data,
  output logic [7:0]            o_instruction,
  output logic                  o_instr_valid,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                r_state;
  logic [7:0]            r_q [DEPTH];
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [7:0]            r_instruction;
  logic                  r_instr_valid;

  state_t                w_state_next;
  logic [7:0]            w_q_next [DEPTH];
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         w_slot;
  logic [ADDR_WIDTH-1:0] w_fetch_addr_next;
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_ack;
  logic                  w_push;
  logic                  w_pop;

  // An ack only counts against an outstanding request; a DISCARD ack is swallowed.
  assign w_ack  = i_mem_ack && r_mem_req;
  assign w_push = w_ack && (r_state == ST_REQ) && !i_pc_load;
  assign w_pop  = r_instr_valid && !i_fetch_suppress && !i_pc_load;

  // Shift-register queue: entry 0 is always the head, pushes land after the survivors.
  always_comb begin
    w_q_next     = r_q;
    w_count_next = r_count;
    w_slot       = r_count - CW'(w_pop);
    if (i_pc_load) begin
      w_count_next = {CW{1'b0}};
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          w_q_next[i] = r_q[i+1];
        end
      end
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(w_slot)) begin
            w_q_next[i] = i_mem_data;
          end else begin
            w_q_next[i] = w_q_next[i];
          end
        end
      end
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Program counter and next fetch address; a redirect overrides push/pop.
  always_comb begin
    w_pc_next         = r_pc;
    w_fetch_addr_next = r_fetch_addr;
    if (i_pc_load) begin
      w_pc_next         = i_pc_load_value;
      w_fetch_addr_next = i_pc_load_value;
    end else begin
      if (w_pop) begin
        w_pc_next = r_pc + ADDR_WIDTH'(1);
      end else begin
        w_pc_next = r_pc;
      end
      if (w_push) begin
        w_fetch_addr_next = r_fetch_addr + ADDR_WIDTH'(1);
      end else begin
        w_fetch_addr_next = r_fetch_addr;
      end
    end
  end

  // Fetch FSM next state; mem_addr only moves when a new request is launched.
  always_comb begin
    w_state_next    = r_state;
    w_mem_addr_next = r_mem_addr;
    case (r_state)
      ST_IDLE: begin
        if (w_count_next < CW'(DEPTH)) begin
          w_state_next    = ST_REQ;
          w_mem_addr_next = w_fetch_addr_next;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_ack) begin
          if (w_count_next < CW'(DEPTH)) begin
            w_state_next    = ST_REQ;
            w_mem_addr_next = w_fetch_addr_next;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (i_pc_load) begin
          w_state_next = ST_DISCARD;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (w_ack) begin
          w_state_next    = ST_REQ;
          w_mem_addr_next = w_fetch_addr_next;
        end else begin
          w_state_next = ST_DISCARD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // All state and every output is registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_count       <= {CW{1'b0}};
      r_fetch_addr  <= RESET_VECTOR;
      r_mem_addr    <= RESET_VECTOR;
      r_mem_req     <= 1'b0;
      r_pc          <= RESET_VECTOR;
      r_instruction <= NOP;
      r_instr_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= NOP;
      end
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      r_fetch_addr  <= w_fetch_addr_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_req     <= (w_state_next != ST_IDLE);
      r_pc          <= w_pc_next;
      r_instruction <= (w_count_next != {CW{1'b0}}) ? w_q_next[0] : NOP;
      r_instr_valid <= (w_count_next != {CW{1'b0}});
      r_q           <= w_q_next;
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instruction = r_instruction;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;

endmodule
